simple_buffer_v: RTL and testbench
==================================

Name: simple_buffer_v

Overview:
- 8-bit handshaked receive-side buffer for the point-to-point data connection.
- Accepts bytes from an upstream source over a valid/ready interface and stores them in a small circular FIFO.
- Presents the stored bytes, first-word-fall-through, to a downstream consumer.
- Decouples the two ends of the link so a stalled consumer does not lose data.

Parameters:
- WIDTH, 8, data width in bits of d_in, mem entries and d_out.
- DEPTH, 4, number of entries; power of two, >= 2; pointer width AW = $clog2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- d_in  input  WIDTH  data input from the upstream source.
- in_valid  input  1  upstream asserts when d_in holds a valid byte.
- in_ready  output  1  buffer can accept a byte this cycle.
- d_out  output  WIDTH  data output; head-of-FIFO entry.
- out_valid  output  1  d_out holds a valid byte.
- out_ready  input  1  downstream accepts d_out this cycle.
- count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset, with resetn=0 at a rising edge:
  - wr_ptr=0, rd_ptr=0, count=0.
  - All mem entries cleared to 0.
  - Outputs after reset: in_ready=1, out_valid=0, d_out=0, count=0.
- Reset mid-operation discards all stored data and has priority over a push or pop in the same cycle.
- Handshake definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Transfer occurs only on the rising edge where the condition is true.
- Flag and data decode:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - d_out = mem[rd_ptr].
  - All three are decoded only from registered state.
  - No combinational path from in_valid or out_ready to any output.
- Push: mem[wr_ptr] <= d_in; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH. The popped entry is not cleared.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Latency: a byte pushed at edge N appears on d_out, with out_valid=1 if the buffer was empty, from edge N onward. It is first poppable at edge N+1. There is no same-cycle bypass.
- Full (count=DEPTH):
  - in_ready=0, so in_valid is ignored and d_in is not written.
  - A pop that cycle lowers count to DEPTH-1; in_ready returns the following cycle.
- Empty (count=0):
  - out_valid=0 and out_ready is ignored.
  - d_out shows the stale mem[rd_ptr]; the consumer must ignore it.
- Simultaneous push and pop with 0<count<DEPTH: both pointers advance, count holds, ordering is preserved.
- Ordering: strict FIFO. Bytes exit in acceptance order, with no duplication and no loss.
- Upstream rule: d_in and in_valid must stay stable while in_valid=1 and in_ready=0. The buffer does not check this.
- Downstream guarantee: d_out and out_valid stay stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset check: hold resetn=0 for 2 clk -> in_ready=1, out_valid=0, count=0, d_out=8'h00. Then, with resetn=1 and idle inputs for 3 cycles -> outputs unchanged.
- Single transfer: push 8'hA5 with out_ready=0 -> after the edge, count=1, out_valid=1, d_out=8'hA5. Next cycle out_ready=1 -> after the edge, count=0, out_valid=0.
- Fill to full: push 8'h01, 8'h02, 8'h03, 8'h04 with out_ready=0 -> count=4, in_ready=0. Then offer 8'h05 for 3 cycles -> count stays 4 and 8'h05 is not stored. Drain -> d_out sequence 01, 02, 03, 04, then out_valid=0.
- Concurrent push/pop with pointer wrap: count=2, in_valid=1 and out_ready=1 for 10 cycles with d_in 8'h10..8'h19 -> count stays 2 throughout; output stream is the 2 preloaded bytes followed by 8'h10..8'h17; pointers wrap at least twice.
- Full with pop: count=4, in_valid=1 and out_ready=1 in one cycle -> that edge pops only and count=3. Next cycle in_ready=1 and the held byte is accepted.
- Reset mid-operation: count=3, assert resetn=0 for 1 cycle while in_valid=1 and out_ready=1 -> count=0, out_valid=0, d_out=8'h00, in_ready=1. No pre-reset byte ever reappears on d_out.

Source files
------------

// File: rtl/simple_buffer_v_if.sv
// Valid/ready bundle between the upstream source, the receive buffer and the downstream consumer.
// The buffer takes the slave modport; the driving side takes master.
interface simple_buffer_v_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] d_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d_out;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;

  modport slave (
    input  d_in, in_valid, out_ready,
    output in_ready, d_out, out_valid, count
  );

  modport master (
    output d_in, in_valid, out_ready,
    input  in_ready, d_out, out_valid, count
  );
endinterface

// File: rtl/simple_buffer_v.sv
// Receive-side circular FIFO buffer with first-word-fall-through output.
// All flags and d_out are decoded purely from registered state.
module simple_buffer_v #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  simple_buffer_v_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  logic in_ready_s;
  logic out_valid_s;
  logic push_s;
  logic pop_s;

  // Handshake decode from registered occupancy only
  always_comb begin
    in_ready_s  = (count_r != CNT_FULL);
    out_valid_s = (count_r != '0);
    push_s      = bus.in_valid & in_ready_s;
    pop_s       = out_valid_s & bus.out_ready;
  end

  // Storage, pointers and occupancy; reset wipes contents so no stale byte survives
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.d_in;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.d_out     = mem_r[rd_ptr_r];
  assign bus.count     = count_r;
endmodule

// File: tb/tb_simple_buffer_v.sv
// Directed self-checking bench for simple_buffer_v.
// Inputs change 1ns after each rising edge; outputs are checked in the same window.
module tb_simple_buffer_v;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  simple_buffer_v_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  simple_buffer_v #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.d_in     = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_count"},     32'(bus.count),     32'd0);
    chk({tag, "_d_out"},     32'(bus.d_out),     32'h00);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    resetn       = 1'b0;
    bus.d_in     = 8'h00;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset, then idle
    step();
    step();
    chk_idle("reset");
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_idle("idle");

    // Single transfer
    push_byte(8'hA5);
    chk("single_count", 32'(bus.count), 32'd1);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_dout", 32'(bus.d_out), 32'hA5);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("single_pop_count", 32'(bus.count), 32'd0);
    chk("single_pop_valid", 32'(bus.out_valid), 32'd0);

    // Fill to full, offer an extra byte, then drain
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.d_in     = 8'h05;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_count", 32'(bus.count), 32'd4);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_dout", 32'(bus.d_out), 32'(i));
      step();
    end
    bus.out_ready = 1'b0;
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("drain_count", 32'(bus.count), 32'd0);

    // Concurrent push/pop across several pointer wraps
    push_byte(8'hC1);
    push_byte(8'hC2);
    exp_q = '{8'hC1, 8'hC2};
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.d_in = 8'h10 + 8'(i);
      exp_b = exp_q.pop_front();
      chk("conc_dout", 32'(bus.d_out), 32'(exp_b));
      exp_q.push_back(bus.d_in);
      step();
      chk("conc_count", 32'(bus.count), 32'd2);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Full with pop: only the pop happens, held byte taken next cycle
    push_byte(8'h20);
    push_byte(8'h21);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    chk("fp_full", 32'(bus.count), 32'd4);
    bus.in_valid  = 1'b1;
    bus.d_in      = 8'h22;
    bus.out_ready = 1'b1;
    exp_b = exp_q.pop_front();
    chk("fp_dout", 32'(bus.d_out), 32'(exp_b));
    step();
    chk("fp_count", 32'(bus.count), 32'd3);
    chk("fp_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    exp_q.push_back(8'h22);
    chk("fp_accept_count", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = exp_q.pop_front();
      chk("fp_drain_dout", 32'(bus.d_out), 32'(exp_b));
      step();
    end
    bus.out_ready = 1'b0;
    chk("fp_drain_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation wins over push and pop
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    chk("mid_pre_count", 32'(bus.count), 32'd3);
    resetn        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.d_in      = 8'h44;
    bus.out_ready = 1'b1;
    step();
    resetn        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk_idle("midrst");
    step();
    chk_idle("midrst_idle");
    push_byte(8'h55);
    chk("post_dout", 32'(bus.d_out), 32'h55);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_count", 32'(bus.count), 32'd0);
    chk("post_stale_dout", 32'(bus.d_out), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
